multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle LEGv8 control sequencer. It drives the shared-ALU, single-memory datapath (PC, IR, register bank, ALU, unified memory) one instruction phase per state.
- Replaces the combinational per-instruction decode with an FSM that has a memory wait-state handshake and a memory watchdog.
- Sits beside the datapath:
  - consumes IR opcode, ALU Zero and memory ready;
  - produces every datapath enable and select.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles a state may wait for mem_ready before a memory fault.
- WAIT_W, 4: width of the wait counter; must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  11  IR[31:21], valid from the cycle after IR_write.
- Zero  in  1  ALU zero flag, combinational in the current cycle.
- mem_ready  in  1  memory completes the current MemRead/MemWrite this cycle.
- PC_write  out  1  load PC.
- PCSource  out  1  PC mux select: 0 = ALU result, 1 = ALUOut register.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IR_write  out  1  load IR from memory data.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- Reg2Loc  out  1  read register 2 select: 0 = Rm, 1 = Rt.
- RegWrite  out  1  register bank write enable.
- MemtoReg  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- ALUOp  out  2  ALU control: 00 = add, 01 = pass B, 10 = R-type function field.
- state  out  4  current state encoding, for debug.
- illegal_op  out  1  sticky: undecodable opcode seen.
- mem_fault  out  1  sticky: watchdog expired.

Behaviour:
- State encodings: FETCH=0, DECODE=1, R_EXEC=2, R_WB=3, ADDR=4, LD_MEM=5, LD_WB=6, ST_MEM=7, CBZ=8, B=9, HALT=15.
- Reset, synchronous: state=FETCH, wait counter=0, illegal_op=0, mem_fault=0. While reset=1, every control output is forced to 0. The first FETCH begins in the cycle after reset deasserts.
- Output timing: all outputs are Moore functions of state, except the handshake qualifiers listed below, which are asserted only in cycles with mem_ready=1.
- Unlisted outputs are 0 in every state.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - When mem_ready=1: IR_write=1, PC_write=1, PCSource=0, then go to DECODE. Otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Reg2Loc=1 when opcode is STUR or CBZ. Next state by opcode:
  - 10001011000 (ADD), 11001011000 (SUB), 10001010000 (AND), 10101010000 (ORR) -> R_EXEC.
  - 11111000010 (LDUR), 11111000000 (STUR) -> ADDR.
  - 10110100xxx -> CBZ.
  - 000101xxxxx -> B.
  - Any other opcode -> set illegal_op, go to FETCH. The instruction is skipped; PC has already advanced by 4.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then R_WB.
- R_WB: RegWrite=1, MemtoReg=0, then FETCH.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, Reg2Loc=1. Next is LD_MEM for LDUR, ST_MEM for STUR.
- LD_MEM: MemRead=1, IorD=1. Waits for mem_ready, then LD_WB.
- LD_WB: RegWrite=1, MemtoReg=1, then FETCH.
- ST_MEM: MemWrite=1, IorD=1, Reg2Loc=1. Waits for mem_ready, then FETCH.
- CBZ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Reg2Loc=1, PCSource=1, PC_write=Zero, then FETCH.
- B: PCSource=1, PC_write=1, then FETCH.
- Cycle counts with zero-wait memory: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3.
- Watchdog, in FETCH, LD_MEM and ST_MEM only:
  - The counter clears on state entry and increments each cycle with mem_ready=0.
  - If the counter equals MEM_WAIT_MAX while mem_ready=0, set mem_fault and go to HALT.
  - mem_ready=1 in that same cycle wins: no fault.
- HALT: all outputs 0. It is left only by reset.
- Reset asserted mid-instruction: abandon the instruction. No partial RegWrite or MemWrite is issued in the reset cycle.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- When defined, two extra outputs exist:
  - retired [31:0]: increments on each transition into FETCH from R_WB, LD_WB, ST_MEM, CBZ or B.
  - stall_cycles [31:0]: increments on each watchdog-counted cycle with mem_ready=0.
- Both counters reset to 0, wrap modulo 2^32, and hold in HALT.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset 3 cycles, then opcode=10001011000 (ADD), mem_ready=1 always:
  - state sequence is 0,1,2,3,0;
  - RegWrite=1 only in state 3 with MemtoReg=0;
  - IR_write=PC_write=1 in the single FETCH cycle.
- LDUR (11111000010), mem_ready low for 3 cycles in LD_MEM:
  - LD_MEM lasts 4 cycles with MemRead=1, IorD=1;
  - LD_WB asserts RegWrite=1, MemtoReg=1;
  - total 8 cycles.
- CBZ (10110100101) with Zero=1: PC_write=1, PCSource=1 in state 8. Repeat with Zero=0: PC_write=0. Both return to FETCH.
- Opcode 11111111111: illegal_op=1 after DECODE, next state FETCH, no RegWrite or MemWrite. illegal_op stays 1 until reset.
- mem_ready held 0 in FETCH:
  - mem_fault=1 and state=15 after MEM_WAIT_MAX+1 cycles;
  - holds across 20 further cycles;
  - reset returns state=0 and mem_fault=0.
- Reset asserted during ST_MEM with mem_ready=0: MemWrite=0 in the reset cycle, and state=FETCH after reset deasserts.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control FSM with a memory wait-state handshake and a memory watchdog.
// Define MC_PERF_CNT_EN to add the retired / stall_cycles performance counters.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PC_write,
  output logic        PCSource,
  output logic        IorD,
  output logic        IR_write,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Reg2Loc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic        mem_fault
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] retired,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_R_EXEC = 4'd2,
    S_R_WB   = 4'd3,
    S_ADDR   = 4'd4,
    S_LD_MEM = 4'd5,
    S_LD_WB  = 4'd6,
    S_ST_MEM = 4'd7,
    S_CBZ    = 4'd8,
    S_B      = 4'd9,
    S_HALT   = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg2loc;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  state_t            cur, nxt;
  ctl_t              ctl;
  logic [WAIT_W-1:0] wait_cnt;
  logic              watched, set_illegal, set_fault, wait_hit;
  logic              is_rtype, is_ldur, is_stur, is_cbz, is_b;

  assign is_rtype = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                    (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
  assign is_ldur  = (opcode == 11'b11111000010);
  assign is_stur  = (opcode == 11'b11111000000);
  assign is_cbz   = (opcode[10:3] == 8'b10110100);
  assign is_b     = (opcode[10:5] == 6'b000101);
  assign wait_hit = (wait_cnt == WAIT_W'(MEM_WAIT_MAX));

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    ctl         = '0;
    nxt         = cur;
    watched     = 1'b0;
    set_illegal = 1'b0;
    set_fault   = 1'b0;
    unique case (cur)
      S_FETCH: begin
        watched           = 1'b1;
        ctl.mem_read      = 1'b1;
        ctl.alu_src_b     = 2'b01;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          nxt          = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl.alu_src_b = 2'b11;
        ctl.reg2loc   = is_stur || is_cbz;
        if (is_rtype)                nxt = S_R_EXEC;
        else if (is_ldur || is_stur) nxt = S_ADDR;
        else if (is_cbz)             nxt = S_CBZ;
        else if (is_b)               nxt = S_B;
        else begin
          set_illegal = 1'b1;
          nxt         = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
        nxt           = S_R_WB;
      end
      S_R_WB: begin
        ctl.reg_write = 1'b1;
        nxt           = S_FETCH;
      end
      S_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.reg2loc   = 1'b1;
        nxt           = is_ldur ? S_LD_MEM : (is_stur ? S_ST_MEM : S_FETCH);
      end
      S_LD_MEM: begin
        watched      = 1'b1;
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
        if (mem_ready) nxt = S_LD_WB;
      end
      S_LD_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        nxt            = S_FETCH;
      end
      S_ST_MEM: begin
        watched       = 1'b1;
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
        ctl.reg2loc   = 1'b1;
        if (mem_ready) nxt = S_FETCH;
      end
      S_CBZ: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b01;
        ctl.reg2loc   = 1'b1;
        ctl.pc_source = 1'b1;
        ctl.pc_write  = Zero;
        nxt           = S_FETCH;
      end
      S_B: begin
        ctl.pc_source = 1'b1;
        ctl.pc_write  = 1'b1;
        nxt           = S_FETCH;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase

    // A ready in the deadline cycle still completes the access.
    if (watched && !mem_ready && wait_hit) begin
      nxt       = S_HALT;
      set_fault = 1'b1;
    end

    // Reset abandons the instruction, so nothing partial reaches the datapath.
    if (reset) ctl = '0;
  end

  assign {PC_write, PCSource, IorD, IR_write, MemRead, MemWrite, Reg2Loc,
          RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp} = ctl;
  assign state = cur;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= S_FETCH;
      wait_cnt   <= '0;
      illegal_op <= 1'b0;
      mem_fault  <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur)                wait_cnt <= '0;
      else if (watched && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (set_illegal) illegal_op <= 1'b1;
      if (set_fault)   mem_fault  <= 1'b1;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic retire;
  assign retire = (nxt == S_FETCH) &&
                  (cur inside {S_R_WB, S_LD_WB, S_ST_MEM, S_CBZ, S_B});

  always_ff @(posedge clk) begin
    if (reset) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else if (cur != S_HALT) begin
      if (retire)                  retired      <= retired + 32'd1;
      if (watched && !mem_ready)   stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: cycle-accurate vector table, hand-written
// watchdog/reset sequences, and randomized instructions against a phase-list model.
module tb_multicycle_control;

  localparam int MEM_WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] opcode = '0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PC_write, PCSource, IorD, IR_write, MemRead, MemWrite;
  logic        Reg2Loc, RegWrite, MemtoReg, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic        illegal_op, mem_fault;
`ifdef MC_PERF_CNT_EN
  logic [31:0] retired, stall_cycles;
`endif

  multicycle_control #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PC_write(PC_write), .PCSource(PCSource), .IorD(IorD), .IR_write(IR_write),
    .MemRead(MemRead), .MemWrite(MemWrite), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .state(state), .illegal_op(illegal_op), .mem_fault(mem_fault)
`ifdef MC_PERF_CNT_EN
    , .retired(retired), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // {PC_write,PCSource,IorD,IR_write,MemRead,MemWrite,Reg2Loc,RegWrite,MemtoReg,ALUSrcA,ALUSrcB,ALUOp}
  logic [13:0] ctl_act;
  assign ctl_act = {PC_write, PCSource, IorD, IR_write, MemRead, MemWrite, Reg2Loc,
                    RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp};

  localparam logic [13:0] K_ZERO    = 14'b00000000000000;
  localparam logic [13:0] K_FETCH_R = 14'b10011000000100;
  localparam logic [13:0] K_FETCH_W = 14'b00001000000100;
  localparam logic [13:0] K_DEC     = 14'b00000000001100;
  localparam logic [13:0] K_DEC_R2L = 14'b00000010001100;
  localparam logic [13:0] K_REXEC   = 14'b00000000010010;
  localparam logic [13:0] K_RWB     = 14'b00000001000000;
  localparam logic [13:0] K_ADDR    = 14'b00000010011000;
  localparam logic [13:0] K_LDM     = 14'b00101000000000;
  localparam logic [13:0] K_LDWB    = 14'b00000001100000;
  localparam logic [13:0] K_STM     = 14'b00100110000000;
  localparam logic [13:0] K_CBZ1    = 14'b11000010010001;
  localparam logic [13:0] K_CBZ0    = 14'b01000010010001;
  localparam logic [13:0] K_B       = 14'b11000000000000;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_ILL  = 11'b11111111111;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

  typedef struct {
    logic        rst;
    logic [10:0] op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [13:0] ctl;
    logic        ill;
  } vec_t;

  vec_t        vecs[$];
  logic [3:0]  exp_s[$];
  bit          rdy_q[$];
  logic [10:0] r_ops[4]   = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
  logic [10:0] ill_ops[4] = '{11'b11111111111, 11'b00000000000, 11'b10001011001, 11'b11111000001};
  int          n_checks = 0;
  int          n_fail = 0;
  logic        exp_ill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic add_vec(input logic rst, input logic [10:0] op, input logic z, input logic rdy,
                         input logic [3:0] st, input logic [13:0] ctl, input logic ill);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic push_ph(input logic [3:0] st, input bit rdy);
    exp_s.push_back(st);
    rdy_q.push_back(rdy);
  endtask

  // Reference model: an instruction is a list of phases; memory phases stretch by their wait count.
  task automatic run_instr(input int cls, input int fw, input int mw, input logic z);
    logic [10:0] op;
    int n_mr = 0, n_mw = 0, n_rw = 0, n_pcw = 0, n_irw = 0, n_r2l = 0;
    int e_mr, e_mw, e_rw, e_pcw, e_r2l;
    exp_s.delete();
    rdy_q.delete();
    case (cls)
      C_R:     op = r_ops[$urandom_range(0, 3)];
      C_LD:    op = OP_LDUR;
      C_ST:    op = OP_STUR;
      C_CBZ:   op = {8'b10110100, 3'($urandom_range(0, 7))};
      C_B:     op = {6'b000101, 5'($urandom_range(0, 31))};
      default: op = ill_ops[$urandom_range(0, 3)];
    endcase
    for (int i = 0; i < fw; i++) push_ph(4'd0, 1'b0);
    push_ph(4'd0, 1'b1);
    push_ph(4'd1, 1'($urandom_range(0, 1)));
    case (cls)
      C_R: begin push_ph(4'd2, 1'($urandom_range(0, 1))); push_ph(4'd3, 1'($urandom_range(0, 1))); end
      C_LD: begin
        push_ph(4'd4, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) push_ph(4'd5, 1'b0);
        push_ph(4'd5, 1'b1);
        push_ph(4'd6, 1'($urandom_range(0, 1)));
      end
      C_ST: begin
        push_ph(4'd4, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) push_ph(4'd7, 1'b0);
        push_ph(4'd7, 1'b1);
      end
      C_CBZ:   push_ph(4'd8, 1'($urandom_range(0, 1)));
      C_B:     push_ph(4'd9, 1'($urandom_range(0, 1)));
      default: ;
    endcase

    for (int i = 0; i < exp_s.size(); i++) begin
      opcode    = (i <= fw) ? 11'($urandom) : op;
      mem_ready = rdy_q[i];
      Zero      = z;
      #1;
      check("rand_state", 32'(state), 32'(exp_s[i]));
      n_mr  += int'(MemRead);
      n_mw  += int'(MemWrite);
      n_rw  += int'(RegWrite);
      n_pcw += int'(PC_write);
      n_irw += int'(IR_write);
      n_r2l += int'(Reg2Loc);
      tick();
    end

    exp_ill = exp_ill | (cls == C_ILL);
    e_mr  = fw + 1 + ((cls == C_LD) ? mw + 1 : 0);
    e_mw  = (cls == C_ST) ? mw + 1 : 0;
    e_rw  = (cls == C_R || cls == C_LD) ? 1 : 0;
    e_pcw = 1 + ((cls == C_B) ? 1 : 0) + ((cls == C_CBZ && z) ? 1 : 0);
    e_r2l = (cls == C_ST) ? mw + 3 : (cls == C_LD) ? 1 : (cls == C_CBZ) ? 2 : 0;
    check("rand_end_state", 32'(state), 32'd0);
    check("rand_memread_cycles", 32'(n_mr), 32'(e_mr));
    check("rand_memwrite_cycles", 32'(n_mw), 32'(e_mw));
    check("rand_regwrite_cycles", 32'(n_rw), 32'(e_rw));
    check("rand_pcwrite_cycles", 32'(n_pcw), 32'(e_pcw));
    check("rand_irwrite_cycles", 32'(n_irw), 32'd1);
    check("rand_reg2loc_cycles", 32'(n_r2l), 32'(e_r2l));
    check("rand_illegal_op", 32'(illegal_op), 32'(exp_ill));
    check("rand_mem_fault", 32'(mem_fault), 32'd0);
  endtask

  initial begin
    // Reset rows present ready/Zero high to show outputs are still forced low.
    add_vec(1, OP_ADD, 1, 1, 4'd0, K_ZERO, 0);
    add_vec(1, OP_ADD, 1, 1, 4'd0, K_ZERO, 0);
    add_vec(0, OP_ADD, 1, 1, 4'd0, K_FETCH_R, 0);
    add_vec(0, OP_ADD, 1, 0, 4'd1, K_DEC, 0);
    add_vec(0, OP_ADD, 1, 0, 4'd2, K_REXEC, 0);
    add_vec(0, OP_ADD, 1, 0, 4'd3, K_RWB, 0);
    add_vec(0, OP_CBZ, 1, 0, 4'd0, K_FETCH_W, 0);
    add_vec(0, OP_CBZ, 1, 1, 4'd0, K_FETCH_R, 0);
    add_vec(0, OP_CBZ, 1, 0, 4'd1, K_DEC_R2L, 0);
    add_vec(0, OP_CBZ, 1, 0, 4'd8, K_CBZ1, 0);
    add_vec(0, OP_CBZ, 0, 1, 4'd0, K_FETCH_R, 0);
    add_vec(0, OP_CBZ, 0, 0, 4'd1, K_DEC_R2L, 0);
    add_vec(0, OP_CBZ, 0, 0, 4'd8, K_CBZ0, 0);
    add_vec(0, OP_B,   1, 1, 4'd0, K_FETCH_R, 0);
    add_vec(0, OP_B,   1, 0, 4'd1, K_DEC, 0);
    add_vec(0, OP_B,   0, 0, 4'd9, K_B, 0);
    add_vec(0, OP_LDUR, 1, 1, 4'd0, K_FETCH_R, 0);
    add_vec(0, OP_LDUR, 1, 0, 4'd1, K_DEC, 0);
    add_vec(0, OP_LDUR, 1, 0, 4'd4, K_ADDR, 0);
    add_vec(0, OP_LDUR, 1, 0, 4'd5, K_LDM, 0);
    add_vec(0, OP_LDUR, 1, 0, 4'd5, K_LDM, 0);
    add_vec(0, OP_LDUR, 1, 0, 4'd5, K_LDM, 0);
    add_vec(0, OP_LDUR, 1, 1, 4'd5, K_LDM, 0);
    add_vec(0, OP_LDUR, 1, 0, 4'd6, K_LDWB, 0);
    add_vec(0, OP_STUR, 1, 1, 4'd0, K_FETCH_R, 0);
    add_vec(0, OP_STUR, 1, 0, 4'd1, K_DEC_R2L, 0);
    add_vec(0, OP_STUR, 1, 0, 4'd4, K_ADDR, 0);
    add_vec(0, OP_STUR, 1, 0, 4'd7, K_STM, 0);
    add_vec(0, OP_STUR, 1, 1, 4'd7, K_STM, 0);
    add_vec(0, OP_ILL, 1, 1, 4'd0, K_FETCH_R, 0);
    add_vec(0, OP_ILL, 1, 0, 4'd1, K_DEC, 0);
    add_vec(0, OP_ADD, 1, 1, 4'd0, K_FETCH_R, 1);
    add_vec(0, OP_ADD, 1, 0, 4'd1, K_DEC, 1);
    add_vec(0, OP_ADD, 1, 0, 4'd2, K_REXEC, 1);
    add_vec(0, OP_ADD, 1, 0, 4'd3, K_RWB, 1);
    add_vec(0, OP_ADD, 1, 0, 4'd0, K_FETCH_W, 1);

    tick();
    foreach (vecs[i]) begin
      reset = vecs[i].rst; opcode = vecs[i].op; Zero = vecs[i].z; mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_ctl", i), 32'(ctl_act), 32'(vecs[i].ctl));
      check($sformatf("vec%0d_illegal_op", i), 32'(illegal_op), 32'(vecs[i].ill));
      check($sformatf("vec%0d_mem_fault", i), 32'(mem_fault), 32'd0);
      tick();
    end

    // Ready arriving in the deadline cycle wins over the watchdog.
    do_reset(1);
    check("rst_clears_illegal", 32'(illegal_op), 32'd0);
    opcode = OP_ADD;
    for (int i = 0; i < MEM_WAIT_MAX; i++) tick();
    mem_ready = 1'b1;
    #1;
    check("wd_edge_irwrite", 32'(IR_write), 32'd1);
    tick();
    mem_ready = 1'b0;
    check("wd_edge_state", 32'(state), 32'd1);
    check("wd_edge_no_fault", 32'(mem_fault), 32'd0);

    // Ready withheld in FETCH: fault after MEM_WAIT_MAX+1 cycles, HALT holds until reset.
    do_reset(1);
    for (int i = 0; i <= MEM_WAIT_MAX; i++) begin
      #1;
      if (i == MEM_WAIT_MAX) begin
        check("wd_last_wait_state", 32'(state), 32'd0);
        check("wd_last_wait_fault", 32'(mem_fault), 32'd0);
      end
      tick();
    end
    check("wd_halt_state", 32'(state), 32'd15);
    check("wd_fault_set", 32'(mem_fault), 32'd1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      opcode = 11'($urandom);
      Zero = 1'($urandom_range(0, 1));
      #1;
      check("halt_state", 32'(state), 32'd15);
      check("halt_ctl", 32'(ctl_act), 32'd0);
      check("halt_fault", 32'(mem_fault), 32'd1);
      tick();
    end
    do_reset(1);
    check("halt_exit_state", 32'(state), 32'd0);
    check("halt_exit_fault", 32'(mem_fault), 32'd0);

    // Reset during a stalled store suppresses MemWrite in the reset cycle.
    opcode = OP_STUR;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    #1;
    check("stm_state", 32'(state), 32'd7);
    check("stm_memwrite", 32'(MemWrite), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    check("rst_stm_memwrite", 32'(MemWrite), 32'd0);
    check("rst_stm_regwrite", 32'(RegWrite), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_stm_state", 32'(state), 32'd0);
    check("rst_stm_fetch_read", 32'(MemRead), 32'd1);

    // Randomized instruction stream.
    do_reset(2);
    exp_ill = 1'b0;
    for (int n = 0; n < 200; n++) begin
      int cls, fw, mw;
      cls = $urandom_range(0, 5);
      fw  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MEM_WAIT_MAX) : $urandom_range(0, 2);
      mw  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MEM_WAIT_MAX) : $urandom_range(0, 2);
      run_instr(cls, fw, mw, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
